sifive_insight_tl_d_arbiter: RTL and testbench

Round-robin arbiter that merges NUM_SRC TileLink D-channel response streams, each carrying its own user field, onto one shared D channel feeding the Insight instruction-trace bundle. Multi-beat data responses are locked, so the beats of one burst never interleave with another source. The arbiter adds no latency: the output is a combinational mux of the granted source. Only the grant pointer, the lock and the beat counter are registered.

---
 rtl/sifive_insight_tl_d_arbiter.sv | 145 ++++++++++++++
 tb/tb_sifive_insight_tl_d_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sifive_insight_tl_d_arbiter.sv
// Round-robin merge of NUM_SRC TileLink D channels onto one, with multi-beat data
// bursts locked to their source. The output path is purely combinational.
//
// state    | meaning
// unlocked | sel = first valid source scanning from ptr; a multi-beat first beat locks
// locked   | sel = lock_idx until beat_cnt counts the remaining beats down to zero
module sifive_insight_tl_d_arbiter #(
  parameter int NUM_SRC  = 2,
  parameter int DATA_W   = 32,
  parameter int SIZE_W   = 3,
  parameter int SOURCE_W = 4,
  parameter int USER_W   = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_SRC-1:0]           in_valid,
  output logic [NUM_SRC-1:0]           in_ready,
  input  logic [NUM_SRC*3-1:0]         in_opcode,
  input  logic [NUM_SRC*SIZE_W-1:0]    in_size,
  input  logic [NUM_SRC*SOURCE_W-1:0]  in_source,
  input  logic [NUM_SRC-1:0]           in_denied,
  input  logic [NUM_SRC-1:0]           in_corrupt,
  input  logic [NUM_SRC*DATA_W-1:0]    in_data,
  input  logic [NUM_SRC*USER_W-1:0]    in_user,
  output logic                         out_valid,
  output logic [2:0]                   out_opcode,
  output logic [SIZE_W-1:0]            out_size,
  output logic [SOURCE_W-1:0]          out_source,
  output logic                         out_denied,
  output logic                         out_corrupt,
  output logic [DATA_W-1:0]            out_data,
  output logic [USER_W-1:0]            out_user,
  input  logic                         out_ready,
  output logic [1:0]                   grant_idx,
  output logic                         locked
);

  localparam int BEAT_LG = $clog2(DATA_W / 8);
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] OP_GRANT_DATA      = 3'd5;

  logic [1:0] ptr;
  logic [1:0] lock_idx;
  logic       lock;
  logic [7:0] beat_cnt;

  logic [1:0] sel;
  logic [1:0] scan_idx;
  logic [7:0] beats_m1;
  logic       fire;
  logic [3:0] valid_pad;

  // Sources unpacked into 4-entry arrays so a 2-bit index always lands in range.
  logic [2:0]          opc_a     [4];
  logic [SIZE_W-1:0]   size_a    [4];
  logic [SOURCE_W-1:0] source_a  [4];
  logic                denied_a  [4];
  logic                corrupt_a [4];
  logic [DATA_W-1:0]   data_a    [4];
  logic [USER_W-1:0]   user_a    [4];

  assign valid_pad = 4'(in_valid);

  for (genvar g = 0; g < 4; g++) begin : g_unpack
    if (g < NUM_SRC) begin : g_src
      assign opc_a[g]     = in_opcode[g*3 +: 3];
      assign size_a[g]    = in_size[g*SIZE_W +: SIZE_W];
      assign source_a[g]  = in_source[g*SOURCE_W +: SOURCE_W];
      assign denied_a[g]  = in_denied[g];
      assign corrupt_a[g] = in_corrupt[g];
      assign data_a[g]    = in_data[g*DATA_W +: DATA_W];
      assign user_a[g]    = in_user[g*USER_W +: USER_W];
      assign in_ready[g]  = (sel == 2'(g)) & out_ready & ~reset;
    end else begin : g_pad
      assign opc_a[g]     = '0;
      assign size_a[g]    = '0;
      assign source_a[g]  = '0;
      assign denied_a[g]  = 1'b0;
      assign corrupt_a[g] = 1'b0;
      assign data_a[g]    = '0;
      assign user_a[g]    = '0;
    end
  end

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (int'(i) == NUM_SRC - 1) ? 2'd0 : i + 2'd1;
  endfunction

  // Scan from the far end back towards ptr so the nearest valid source wins.
  always_comb begin
    sel      = ptr;
    scan_idx = ptr;
    if (lock) begin
      sel = lock_idx;
    end else begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        scan_idx = 2'((int'(ptr) + i) % NUM_SRC);
        if (valid_pad[scan_idx]) sel = scan_idx;
      end
    end
  end

  always_comb begin
    beats_m1 = 8'd0;
    if ((opc_a[sel] == OP_ACCESS_ACK_DATA || opc_a[sel] == OP_GRANT_DATA) &&
        int'(size_a[sel]) > BEAT_LG)
      beats_m1 = 8'((1 << (int'(size_a[sel]) - BEAT_LG)) - 1);
  end

  assign out_valid   = valid_pad[sel] & ~reset;
  assign out_opcode  = opc_a[sel];
  assign out_size    = size_a[sel];
  assign out_source  = source_a[sel];
  assign out_denied  = denied_a[sel];
  assign out_corrupt = corrupt_a[sel];
  assign out_data    = data_a[sel];
  assign out_user    = user_a[sel];
  assign grant_idx   = reset ? 2'd0 : sel;
  assign locked      = lock & ~reset;
  assign fire        = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr      <= 2'd0;
      lock     <= 1'b0;
      lock_idx <= 2'd0;
      beat_cnt <= 8'd0;
    end else if (fire) begin
      if (lock) begin
        beat_cnt <= beat_cnt - 8'd1;
        if (beat_cnt == 8'd1) begin
          lock <= 1'b0;
          ptr  <= next_idx(lock_idx);
        end
      end else if (beats_m1 != 8'd0) begin
        lock     <= 1'b1;
        lock_idx <= sel;
        beat_cnt <= beats_m1;
      end else begin
        ptr <= next_idx(sel);
      end
    end
  end

endmodule

// File: tb/tb_sifive_insight_tl_d_arbiter.sv
// Directed bench for the D-channel arbiter: fairness, burst locking, backpressure,
// beat-count corner cases and reset in the middle of a burst.
module tb_sifive_insight_tl_d_arbiter;

  localparam int NUM_SRC  = 2;
  localparam int DATA_W   = 32;
  localparam int SIZE_W   = 3;
  localparam int SOURCE_W = 4;
  localparam int USER_W   = 1;

  logic                        clock;
  logic                        reset;
  logic [NUM_SRC-1:0]          in_valid;
  logic [NUM_SRC-1:0]          in_ready;
  logic [NUM_SRC*3-1:0]        in_opcode;
  logic [NUM_SRC*SIZE_W-1:0]   in_size;
  logic [NUM_SRC*SOURCE_W-1:0] in_source;
  logic [NUM_SRC-1:0]          in_denied;
  logic [NUM_SRC-1:0]          in_corrupt;
  logic [NUM_SRC*DATA_W-1:0]   in_data;
  logic [NUM_SRC*USER_W-1:0]   in_user;
  logic                        out_valid;
  logic [2:0]                  out_opcode;
  logic [SIZE_W-1:0]           out_size;
  logic [SOURCE_W-1:0]         out_source;
  logic                        out_denied;
  logic                        out_corrupt;
  logic [DATA_W-1:0]           out_data;
  logic [USER_W-1:0]           out_user;
  logic                        out_ready;
  logic [1:0]                  grant_idx;
  logic                        locked;

  int n_checks = 0;
  int n_pass   = 0;

  sifive_insight_tl_d_arbiter #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
    .SOURCE_W(SOURCE_W), .USER_W(USER_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_size(in_size), .in_source(in_source), .in_denied(in_denied),
    .in_corrupt(in_corrupt), .in_data(in_data), .in_user(in_user),
    .out_valid(out_valid), .out_opcode(out_opcode), .out_size(out_size),
    .out_source(out_source), .out_denied(out_denied), .out_corrupt(out_corrupt),
    .out_data(out_data), .out_user(out_user), .out_ready(out_ready),
    .grant_idx(grant_idx), .locked(locked)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] data_of(input int s);
    return 32'hDA7A_0000 | 32'(s);
  endfunction

  task automatic drive(input int s, input logic v, input logic [2:0] op, input logic [2:0] sz);
    in_valid[s]          = v;
    in_opcode[s*3 +: 3]  = op;
    in_size[s*3 +: 3]    = sz;
    in_source[s*4 +: 4]  = 4'(s + 9);
    in_data[s*32 +: 32]  = data_of(s);
    in_user[s]           = 1'(s);
    in_denied[s]         = 1'(s);
    in_corrupt[s]        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    out_ready  = 1'b1;
    in_valid   = '0;
    in_opcode  = '0;
    in_size    = '0;
    in_source  = '0;
    in_denied  = '0;
    in_corrupt = '0;
    in_data    = '0;
    in_user    = '0;
    drive(0, 1'b1, 3'd0, 3'd2);
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_grant",     64'(grant_idx), 64'd0);
    chk("rst_locked",    64'(locked),    64'd0);

    // single AccessAck from src0
    reset = 1'b0;
    #1;
    chk("single_valid",  64'(out_valid),  64'd1);
    chk("single_ready",  64'(in_ready),   64'b01);
    chk("single_grant",  64'(grant_idx),  64'd0);
    chk("single_data",   64'(out_data),   64'hDA7A_0000);
    chk("single_source", 64'(out_source), 64'd9);
    tick();
    drive(0, 1'b0, 3'd0, 3'd2);
    #1;
    chk("single_ptr",    64'(grant_idx), 64'd1);
    chk("single_locked", 64'(locked),    64'd0);
    chk("single_idle",   64'(out_valid), 64'd0);

    // contention: ptr=1, so grants go 1,0,1,0,1
    drive(0, 1'b1, 3'd0, 3'd2);
    drive(1, 1'b1, 3'd0, 3'd2);
    for (int c = 0; c < 5; c++) begin
      int exp_g;
      exp_g = (c % 2 == 0) ? 1 : 0;
      #1;
      chk("cont_grant", 64'(grant_idx), 64'(exp_g));
      chk("cont_ready", 64'(in_ready),  64'(1 << exp_g));
      chk("cont_user",  64'(out_user),  64'(exp_g));
      chk("cont_deny",  64'(out_denied), 64'(exp_g));
      tick();
    end
    drive(0, 1'b0, 3'd0, 3'd2);
    drive(1, 1'b0, 3'd0, 3'd2);
    #1;
    chk("cont_ptr", 64'(grant_idx), 64'd0);

    // 4-beat AccessAckData from src0 with src1 waiting
    drive(0, 1'b1, 3'd1, 3'd4);
    drive(1, 1'b1, 3'd0, 3'd2);
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk("burst_grant",  64'(grant_idx), 64'((c <= 4) ? 0 : 1));
      chk("burst_locked", 64'(locked),    64'((c >= 2 && c <= 4) ? 1 : 0));
      chk("burst_ready",  64'(in_ready),  64'((c <= 4) ? 1 : 2));
      tick();
      if (c == 4) drive(0, 1'b0, 3'd1, 3'd4);
    end
    drive(1, 1'b0, 3'd0, 3'd2);
    #1;
    chk("burst_ptr", 64'(grant_idx), 64'd0);

    // backpressure on beat 2, then src0 drops valid mid-burst
    drive(0, 1'b1, 3'd1, 3'd4);
    drive(1, 1'b1, 3'd0, 3'd2);
    #1;
    chk("bp_first", 64'(grant_idx), 64'd0);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready",  64'(in_ready),     64'd0);
      chk("bp_valid",  64'(out_valid),    64'd1);
      chk("bp_grant",  64'(grant_idx),    64'd0);
      chk("bp_locked", 64'(locked),       64'd1);
      chk("bp_cnt",    64'(dut.beat_cnt), 64'd3);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume", 64'(in_ready), 64'b01);
    tick();
    drive(0, 1'b0, 3'd1, 3'd4);
    #1;
    chk("drop_valid",  64'(out_valid), 64'd0);
    chk("drop_grant",  64'(grant_idx), 64'd0);
    chk("drop_locked", 64'(locked),    64'd1);
    chk("drop_ready",  64'(in_ready),  64'b01);
    tick();
    chk("drop_cnt", 64'(dut.beat_cnt), 64'd2);
    drive(0, 1'b1, 3'd1, 3'd4);
    #1;
    chk("bp_b3_grant", 64'(grant_idx), 64'd0);
    tick();
    #1;
    chk("bp_b4_grant",  64'(grant_idx), 64'd0);
    chk("bp_b4_locked", 64'(locked),    64'd1);
    tick();
    drive(0, 1'b0, 3'd1, 3'd4);
    #1;
    chk("bp_src1_grant",  64'(grant_idx), 64'd1);
    chk("bp_src1_locked", 64'(locked),    64'd0);
    tick();
    drive(1, 1'b0, 3'd0, 3'd2);
    #1;
    chk("bp_ptr", 64'(grant_idx), 64'd0);

    // AccessAck size 5 is single-beat
    drive(0, 1'b1, 3'd0, 3'd5);
    #1;
    chk("aa5_valid", 64'(out_valid), 64'd1);
    tick();
    drive(0, 1'b0, 3'd0, 3'd5);
    #1;
    chk("aa5_locked", 64'(locked),    64'd0);
    chk("aa5_ptr",    64'(grant_idx), 64'd1);

    // AccessAckData size 1 is single-beat
    drive(1, 1'b1, 3'd1, 3'd1);
    #1;
    chk("aad1_grant", 64'(grant_idx), 64'd1);
    tick();
    drive(1, 1'b0, 3'd1, 3'd1);
    #1;
    chk("aad1_locked", 64'(locked),    64'd0);
    chk("aad1_ptr",    64'(grant_idx), 64'd0);

    // GrantData size 5 is 8 beats
    drive(0, 1'b1, 3'd5, 3'd5);
    drive(1, 1'b1, 3'd0, 3'd2);
    for (int c = 1; c <= 9; c++) begin
      #1;
      chk("gd_grant",  64'(grant_idx), 64'((c <= 8) ? 0 : 1));
      chk("gd_locked", 64'(locked),    64'((c >= 2 && c <= 8) ? 1 : 0));
      tick();
      if (c == 8) drive(0, 1'b0, 3'd5, 3'd5);
    end
    drive(1, 1'b0, 3'd0, 3'd2);

    // reset on beat 2 of a 4-beat burst
    drive(0, 1'b1, 3'd1, 3'd4);
    drive(1, 1'b1, 3'd0, 3'd2);
    #1;
    chk("rmb_first", 64'(grant_idx), 64'd0);
    tick();
    chk("rmb_pre_locked", 64'(locked), 64'd1);
    reset = 1'b1;
    #1;
    chk("rmb_locked", 64'(locked),    64'd0);
    chk("rmb_grant",  64'(grant_idx), 64'd0);
    chk("rmb_valid",  64'(out_valid), 64'd0);
    chk("rmb_ready",  64'(in_ready),  64'd0);
    tick();
    reset = 1'b0;
    drive(0, 1'b0, 3'd1, 3'd4);
    #1;
    chk("rmb_after_grant",  64'(grant_idx),    64'd1);
    chk("rmb_after_valid",  64'(out_valid),    64'd1);
    chk("rmb_after_locked", 64'(locked),       64'd0);
    chk("rmb_after_ready",  64'(in_ready),     64'b10);
    chk("rmb_after_cnt",    64'(dut.beat_cnt), 64'd0);
    tick();
    drive(1, 1'b0, 3'd0, 3'd2);
    #1;
    chk("rmb_final_ptr", 64'(grant_idx), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
